// File: rtl/mem_arbiter.sv
// Shares one SRAM-like slave port between instruction fetch and data access,
// with one transaction in flight and a starvation guard for instruction fetch.
//
// state | meaning
// IDLE  | no transaction; arbitrate among unmasked requests
// ADDR  | s_req asserted from latched fields, waiting for s_addr_ok
// DATA  | address accepted, waiting for s_data_ok
module mem_arbiter #(
  parameter int MAX_DATA_STREAK = 4,
  parameter int ADDR_W          = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [31:0]       i_rdata,
  output logic              i_done,
  input  logic              d_req,
  input  logic              d_wr,
  input  logic [3:0]        d_wstrb,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  output logic [31:0]       d_rdata,
  output logic              d_done,
  output logic              stallreq_inst,
  output logic              stallreq_data,
  output logic              s_req,
  output logic              s_wr,
  output logic [3:0]        s_wstrb,
  output logic [ADDR_W-1:0] s_addr,
  output logic [31:0]       s_wdata,
  input  logic              s_addr_ok,
  input  logic              s_data_ok,
  input  logic [31:0]       s_rdata
);
  localparam int STREAK_W = (MAX_DATA_STREAK > 0) ? $clog2(MAX_DATA_STREAK + 1) : 1;
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DATA_STREAK);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_owner_d;
  logic                r_wr;
  logic [3:0]          r_wstrb;
  logic [ADDR_W-1:0]   r_addr;
  logic [31:0]         r_wdata;
  logic [STREAK_W-1:0] r_streak;
  logic [31:0]         r_i_rdata;
  logic [31:0]         r_d_rdata;
  logic                r_i_done;
  logic                r_d_done;

  logic w_pick_inst;
  logic w_grant_i;
  logic w_grant_d;
  logic w_complete;

  // Priority is decided on raw requests; a master whose done is pulsing keeps
  // its priority but cannot be granted, so that cycle may end without a grant.
  assign w_pick_inst = i_req & (~d_req | (r_streak == STREAK_MAX));
  assign w_grant_i   = (r_state == IDLE) & w_pick_inst & ~r_i_done;
  assign w_grant_d   = (r_state == IDLE) & ~w_pick_inst & d_req & ~r_d_done;
  assign w_complete  = (r_state == DATA) & s_data_ok;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (w_grant_i | w_grant_d) w_state_nxt = ADDR;
      ADDR:    if (s_addr_ok) w_state_nxt = DATA;
      DATA:    if (s_data_ok) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_owner_d <= 1'b0;
      r_wr      <= 1'b0;
      r_wstrb   <= 4'b0000;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_streak  <= '0;
    end else if (w_grant_i) begin
      r_owner_d <= 1'b0;
      r_wr      <= 1'b0;
      r_wstrb   <= 4'b0000;
      r_addr    <= i_addr;
      r_wdata   <= '0;
      r_streak  <= '0;
    end else if (w_grant_d) begin
      r_owner_d <= 1'b1;
      r_wr      <= d_wr;
      r_wstrb   <= d_wstrb;
      r_addr    <= d_addr;
      r_wdata   <= d_wdata;
      if (!i_req)                        r_streak <= '0;
      else if (r_streak != STREAK_MAX)   r_streak <= r_streak + STREAK_W'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_i_done  <= 1'b0;
      r_d_done  <= 1'b0;
      r_i_rdata <= '0;
      r_d_rdata <= '0;
    end else begin
      r_i_done <= w_complete & ~r_owner_d;
      r_d_done <= w_complete & r_owner_d;
      if (w_complete & ~r_owner_d)         r_i_rdata <= s_rdata;
      if (w_complete & r_owner_d & ~r_wr)  r_d_rdata <= s_rdata;
    end
  end

  assign s_req         = (r_state == ADDR);
  assign s_wr          = r_wr;
  assign s_wstrb       = r_wstrb;
  assign s_addr        = r_addr;
  assign s_wdata       = r_wdata;
  assign i_rdata       = r_i_rdata;
  assign d_rdata       = r_d_rdata;
  assign i_done        = r_i_done;
  assign d_done        = r_d_done;
  assign stallreq_inst = i_req & ~r_i_done;
  assign stallreq_data = d_req & ~r_d_done;
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed vector table, ordering and reset sequences,
// and a randomized run checked every cycle against a transaction-level model.
module tb_mem_arbiter;
  localparam int MAXS = 4;

  logic        clk = 1'b0;
  logic        resetn;
  logic        i_req, d_req, d_wr;
  logic [31:0] i_addr, d_addr, d_wdata;
  logic [3:0]  d_wstrb;
  logic [31:0] i_rdata, d_rdata;
  logic        i_done, d_done, stallreq_inst, stallreq_data;
  logic        s_req, s_wr;
  logic [3:0]  s_wstrb;
  logic [31:0] s_addr, s_wdata;
  logic        s_addr_ok = 1'b0, s_data_ok = 1'b0;
  logic [31:0] s_rdata = 32'h0;

  int errors = 0;
  int checks = 0;

  mem_arbiter #(.MAX_DATA_STREAK(MAXS), .ADDR_W(32)) dut (
    .clk(clk), .resetn(resetn),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_done(i_done),
    .d_req(d_req), .d_wr(d_wr), .d_wstrb(d_wstrb), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_done(d_done),
    .stallreq_inst(stallreq_inst), .stallreq_data(stallreq_data),
    .s_req(s_req), .s_wr(s_wr), .s_wstrb(s_wstrb), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_addr_ok(s_addr_ok), .s_data_ok(s_data_ok), .s_rdata(s_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Slave: fixed or random handshake latencies, spurious handshakes outside
  // their phase, junk read data except on a genuine read completion.
  int          sl_alat = 0, sl_dlat = 0, sl_cnt = 0;
  bit          sl_ph = 1'b0, sl_wr = 1'b0, sl_rand = 1'b0, force_dok = 1'b0;
  logic [31:0] sl_addr = 32'h0;
  logic [32:0] capq[$];

  function automatic logic [31:0] slave_word(input logic [31:0] a);
    if (a == 32'hBFC0_0000) return 32'h3C08_0001;
    return {a[15:0], ~a[15:0]};
  endfunction

  always @(posedge clk) begin
    #1;
    s_addr_ok = 1'b0;
    s_data_ok = 1'b0;
    s_rdata   = $urandom;
    if (!resetn) begin
      sl_ph  = 1'b0;
      sl_cnt = 0;
    end else if (!sl_ph) begin
      s_data_ok = 1'($urandom_range(0, 1));
      if (!s_req) s_addr_ok = 1'($urandom_range(0, 1));
      else if (sl_cnt >= sl_alat) begin
        s_addr_ok = 1'b1;
        sl_addr   = s_addr;
        sl_wr     = s_wr;
        capq.push_back({s_wr, s_addr});
        sl_ph  = 1'b1;
        sl_cnt = 0;
      end else sl_cnt++;
    end else begin
      s_addr_ok = 1'($urandom_range(0, 1));
      if (sl_cnt >= sl_dlat) begin
        s_data_ok = 1'b1;
        if (!sl_wr) s_rdata = slave_word(sl_addr);
        sl_ph  = 1'b0;
        sl_cnt = 0;
        if (sl_rand) begin
          sl_alat = int'($urandom_range(0, 2));
          sl_dlat = int'($urandom_range(0, 2));
        end
      end else sl_cnt++;
    end
    if (force_dok) s_data_ok = 1'b1;
  end

  // Transaction model: busy/accepted flags plus the arbitration rule written
  // directly from the priority and streak definitions.
  bit          mdl_en = 1'b0;
  bit          m_busy, m_acc, m_own_d, m_idone, m_ddone, m_wr, nid, ndd, inst_first;
  logic [3:0]  m_wstrb;
  logic [31:0] m_addr, m_wdata, m_irdata, m_drdata;
  int          m_streak;

  always @(negedge clk) begin
    if (!resetn) begin
      m_busy = 0; m_acc = 0; m_own_d = 0; m_idone = 0; m_ddone = 0; m_wr = 0;
      m_wstrb = 0; m_addr = 0; m_wdata = 0; m_irdata = 0; m_drdata = 0; m_streak = 0;
    end else if (mdl_en) begin
      chk("m_s_req", s_req, 32'(m_busy && !m_acc));
      if (m_busy && !m_acc) begin
        chk("m_s_addr", s_addr, m_addr);
        chk("m_s_wr", s_wr, m_wr);
        chk("m_s_wstrb", s_wstrb, m_wstrb);
        chk("m_s_wdata", s_wdata, m_wdata);
      end
      chk("m_i_done", i_done, m_idone);
      chk("m_d_done", d_done, m_ddone);
      chk("m_i_rdata", i_rdata, m_irdata);
      chk("m_d_rdata", d_rdata, m_drdata);
      chk("m_stall_i", stallreq_inst, 32'(i_req && !m_idone));
      chk("m_stall_d", stallreq_data, 32'(d_req && !m_ddone));
      nid = 0;
      ndd = 0;
      if (!m_busy) begin
        inst_first = i_req && (!d_req || m_streak == MAXS);
        if (inst_first && !m_idone) begin
          m_busy = 1; m_own_d = 0; m_wr = 0; m_wstrb = 0; m_addr = i_addr; m_wdata = 0;
          m_streak = 0;
        end else if (!inst_first && d_req && !m_ddone) begin
          m_busy = 1; m_own_d = 1; m_wr = d_wr; m_wstrb = d_wstrb; m_addr = d_addr;
          m_wdata = d_wdata;
          m_streak = i_req ? ((m_streak < MAXS) ? m_streak + 1 : MAXS) : 0;
        end
      end else if (!m_acc) begin
        m_acc = s_addr_ok;
      end else if (s_data_ok) begin
        m_busy = 0;
        m_acc  = 0;
        if (m_own_d) begin
          ndd = 1;
          if (!m_wr) m_drdata = s_rdata;
        end else begin
          nid = 1;
          m_irdata = s_rdata;
        end
      end
      m_idone = nid;
      m_ddone = ndd;
    end
  end

  task automatic wait_done(input bit is_d, input bit scr, output int lat);
    lat = 0;
    for (int k = 1; k <= 60; k++) begin
      tick();
      if ((is_d ? d_done : i_done) === 1'b1) begin
        lat = k;
        return;
      end
      if (scr) begin
        if (is_d) begin
          d_addr = $urandom; d_wdata = $urandom;
          d_wr = 1'($urandom_range(0, 1)); d_wstrb = 4'($urandom);
        end else i_addr = $urandom;
      end
    end
    checks++;
    errors++;
    $display("FAIL timeout: no %s_done within 60 cycles", is_d ? "d" : "i");
  endtask

  typedef struct {
    bit          is_d;
    bit          wr;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          alat;
    int          dlat;
    int          exp_lat;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t        vecs[5];
  logic [31:0] ord_exp[7];
  int          lat, lat_i, lat_d;
  bit          seen;

  initial begin
    vecs[0] = '{0, 0, 4'h0, 32'hBFC0_0000, 32'h0,         0, 0, 3, 32'h3C08_0001};
    vecs[1] = '{1, 0, 4'hF, 32'h0000_1234, 32'h0,         0, 0, 3, 32'h1234_EDCB};
    vecs[2] = '{1, 1, 4'h3, 32'h8000_1000, 32'hDEAD_BEEF, 1, 2, 6, 32'h1234_EDCB};
    vecs[3] = '{1, 0, 4'hF, 32'h8000_2000, 32'h0,         5, 0, 8, 32'h2000_DFFF};
    vecs[4] = '{0, 0, 4'h0, 32'h0000_0040, 32'h0,         2, 1, 6, 32'h0040_FFBF};
    ord_exp = '{32'h2000, 32'h2004, 32'h2008, 32'h200C, 32'h00A0, 32'h2010, 32'h2014};

    resetn = 1'b0;
    i_req = 0; d_req = 0; d_wr = 0; d_wstrb = 0;
    i_addr = 0; d_addr = 0; d_wdata = 0;
    #12;
    chk("rst_s_req", s_req, 0);     chk("rst_s_wr", s_wr, 0);
    chk("rst_s_wstrb", s_wstrb, 0); chk("rst_s_addr", s_addr, 0);
    chk("rst_s_wdata", s_wdata, 0); chk("rst_i_done", i_done, 0);
    chk("rst_d_done", d_done, 0);   chk("rst_i_rdata", i_rdata, 0);
    chk("rst_d_rdata", d_rdata, 0);
    tick();
    resetn = 1'b1;
    mdl_en = 1'b1;
    tick();

    for (int v = 0; v < 5; v++) begin
      sl_alat = vecs[v].alat;
      sl_dlat = vecs[v].dlat;
      capq.delete();
      if (vecs[v].is_d) begin
        d_wr = vecs[v].wr; d_wstrb = vecs[v].wstrb; d_addr = vecs[v].addr;
        d_wdata = vecs[v].wdata; d_req = 1'b1;
      end else begin
        i_addr = vecs[v].addr; i_req = 1'b1;
      end
      lat  = 0;
      seen = 0;
      for (int k = 1; k <= 40 && !seen; k++) begin
        tick();
        if ((vecs[v].is_d ? d_done : i_done) === 1'b1) begin
          lat  = k;
          seen = 1;
          chk($sformatf("vec%0d_stall_at_done", v), vecs[v].is_d ? stallreq_data : stallreq_inst, 0);
        end else
          chk($sformatf("vec%0d_stall", v), vecs[v].is_d ? stallreq_data : stallreq_inst, 1);
      end
      i_req = 0;
      d_req = 0;
      chk($sformatf("vec%0d_latency", v), lat, vecs[v].exp_lat);
      chk($sformatf("vec%0d_rdata", v), vecs[v].is_d ? d_rdata : i_rdata, vecs[v].exp_rdata);
      chk($sformatf("vec%0d_grants", v), 32'(capq.size()), 1);
      if (capq.size() > 0) begin
        chk($sformatf("vec%0d_s_addr", v), capq[0][31:0], vecs[v].addr);
        chk($sformatf("vec%0d_s_wr", v), 32'(capq[0][32]), 32'(vecs[v].wr));
      end
      tick();
      tick();
    end

    // simultaneous write and fetch: data first, load result untouched
    sl_alat = 0; sl_dlat = 0;
    capq.delete();
    fork
      begin
        d_wr = 1; d_wstrb = 4'hF; d_addr = 32'h8000_1000; d_wdata = 32'hDEAD_BEEF; d_req = 1;
        wait_done(1, 0, lat_d);
        d_req = 0;
      end
      begin
        i_addr = 32'h0000_0100; i_req = 1;
        wait_done(0, 0, lat_i);
        i_req = 0;
      end
    join
    chk("both_grants", 32'(capq.size()), 2);
    if (capq.size() >= 2) begin
      chk("both_first", capq[0], {1'b1, 32'h8000_1000});
      chk("both_second", capq[1], {1'b0, 32'h0000_0100});
    end
    chk("both_d_rdata", d_rdata, 32'h2000_DFFF);
    chk("both_i_rdata", i_rdata, 32'h0100_FEFF);
    tick();

    // held fetch against six back-to-back loads exercises the streak limit
    capq.delete();
    fork
      begin
        i_addr = 32'h0000_00A0; i_req = 1;
        wait_done(0, 0, lat_i);
        i_req = 0;
      end
      begin
        for (int k = 0; k < 6; k++) begin
          d_wr = 0; d_wstrb = 4'hF; d_addr = 32'h2000 + 32'(4 * k); d_req = 1;
          wait_done(1, 0, lat_d);
        end
        d_req = 0;
      end
    join
    chk("streak_grants", 32'(capq.size()), 7);
    for (int k = 0; k < 7 && k < capq.size(); k++)
      chk($sformatf("streak_order%0d", k), capq[k][31:0], ord_exp[k]);
    chk("streak_d_rdata", d_rdata, 32'h2014_DFEB);
    tick();

    // reset while a write waits in the data phase
    sl_alat = 0; sl_dlat = 10;
    d_wr = 1; d_wstrb = 4'hA; d_addr = 32'h8000_3000; d_wdata = 32'h1234_5678; d_req = 1;
    tick();
    tick();
    #2;
    resetn = 1'b0;
    #1;
    chk("arst_s_req", s_req, 0);     chk("arst_s_wr", s_wr, 0);
    chk("arst_s_wstrb", s_wstrb, 0); chk("arst_s_addr", s_addr, 0);
    chk("arst_s_wdata", s_wdata, 0); chk("arst_d_done", d_done, 0);
    chk("arst_i_rdata", i_rdata, 0); chk("arst_d_rdata", d_rdata, 0);
    d_req = 0;
    @(negedge clk);
    tick();
    resetn = 1'b1;
    force_dok = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("late_dok_d_done", d_done, 0);
      chk("late_dok_s_req", s_req, 0);
    end
    force_dok = 1'b0;
    sl_dlat = 0;
    tick();

    // randomized traffic, inputs scrambled while each request waits
    sl_rand = 1'b1;
    fork
      begin
        for (int k = 0; k < 30; k++) begin
          repeat ($urandom_range(0, 3)) tick();
          i_addr = $urandom; i_req = 1;
          wait_done(0, 1, lat_i);
          i_req = 0;
        end
      end
      begin
        for (int k = 0; k < 30; k++) begin
          repeat ($urandom_range(0, 3)) tick();
          d_wr = 1'($urandom_range(0, 1)); d_wstrb = 4'($urandom);
          d_addr = $urandom; d_wdata = $urandom; d_req = 1;
          wait_done(1, 1, lat_d);
          d_req = 0;
        end
      end
    join
    sl_rand = 1'b0;
    repeat (4) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1);
  end
endmodule
